// File: rtl/opn_sel_sequencer.sv
// Polarity-select sequencer: glitch-free off/normal/invert with dead time on swaps.
// Optional OPN_SEQ_SYNC_EN: defer every mode change to the next Sync_Pulse.
module opn_sel_sequencer #(
    parameter int DEAD_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Cmd_Valid,
    input  logic [1:0]        Cmd_Mode,
    output logic              Cmd_Ready,
    input  logic [DEAD_W-1:0] Dead_Cyc,
    input  logic              Sync_Pulse,
    output logic              Sel_H,
    output logic              Sel_L,
    output logic [1:0]        Mode_Cur,
    output logic              Busy,
    output logic [CNT_W-1:0]  Switch_Cnt
);

`ifdef OPN_SEQ_SYNC_EN
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SYNC_WAIT = 2'd1,
        DEAD      = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd2
    } state_t;
    logic unused_sync;
    assign unused_sync = Sync_Pulse;
`endif

    localparam logic [DEAD_W-1:0] ONE = DEAD_W'(1);

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        pend_q, pend_d;
    logic [DEAD_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]  sw_q, sw_d;
    logic [1:0]        mode_eff;
    logic [DEAD_W-1:0] dead_ld;
    logic              accept;
    logic              bump;

    assign mode_eff = (Cmd_Mode == 2'b11) ? 2'b00 : Cmd_Mode;
    assign dead_ld  = (Dead_Cyc == '0) ? ONE : Dead_Cyc;
    assign accept   = Cmd_Valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        bump    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && (mode_eff != sel_q)) begin
`ifdef OPN_SEQ_SYNC_EN
                    // Dead time is captured now; the counter holds it while waiting.
                    pend_d  = mode_eff;
                    cnt_d   = dead_ld;
                    state_d = SYNC_WAIT;
`else
                    if ((sel_q != 2'b00) && (mode_eff != 2'b00)) begin
                        sel_d   = 2'b00;
                        pend_d  = mode_eff;
                        cnt_d   = dead_ld;
                        state_d = DEAD;
                    end else begin
                        sel_d = mode_eff;
                        bump  = 1'b1;
                    end
`endif
                end
            end
`ifdef OPN_SEQ_SYNC_EN
            SYNC_WAIT: begin
                if (Sync_Pulse) begin
                    if ((sel_q != 2'b00) && (pend_q != 2'b00)) begin
                        sel_d   = 2'b00;
                        state_d = DEAD;
                    end else begin
                        sel_d   = pend_q;
                        bump    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
`endif
            DEAD: begin
                if (cnt_q == ONE) begin
                    sel_d   = pend_q;
                    bump    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        sw_d = (bump && (sw_q != '1)) ? sw_q + CNT_W'(1) : sw_q;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            sel_q   <= 2'b00;
            pend_q  <= 2'b00;
            cnt_q   <= '0;
            sw_q    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
        end
    end

    assign Cmd_Ready  = (state_q == IDLE);
    assign Busy       = ~Cmd_Ready;
    assign Sel_H      = sel_q[1];
    assign Sel_L      = sel_q[0];
    assign Mode_Cur   = sel_q;
    assign Switch_Cnt = sw_q;

endmodule

// File: tb/tb_opn_sel_sequencer.sv
// Self-checking bench for opn_sel_sequencer (default build, 4-bit counter).
// Reference model tracks mode, pending swap gap and saturating count.
module tb_opn_sel_sequencer;

    localparam int DEAD_W = 8;
    localparam int CNT_W  = 4;

    logic              Clock = 1'b0;
    logic              Reset_n = 1'b0;
    logic              Cmd_Valid = 1'b0;
    logic [1:0]        Cmd_Mode = 2'b00;
    logic              Cmd_Ready;
    logic [DEAD_W-1:0] Dead_Cyc = '0;
    logic              Sync_Pulse = 1'b0;
    logic              Sel_H;
    logic              Sel_L;
    logic [1:0]        Mode_Cur;
    logic              Busy;
    logic [CNT_W-1:0]  Switch_Cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int       m_mode = 0;
    int       m_target = 0;
    int       m_gap = 0;
    int       m_cnt = 0;

    opn_sel_sequencer #(.DEAD_W(DEAD_W), .CNT_W(CNT_W)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Cmd_Valid  (Cmd_Valid),
        .Cmd_Mode   (Cmd_Mode),
        .Cmd_Ready  (Cmd_Ready),
        .Dead_Cyc   (Dead_Cyc),
        .Sync_Pulse (Sync_Pulse),
        .Sel_H      (Sel_H),
        .Sel_L      (Sel_L),
        .Mode_Cur   (Mode_Cur),
        .Busy       (Busy),
        .Switch_Cnt (Switch_Cnt)
    );

    always #5 Clock = ~Clock;

    task automatic drive(input logic v, input logic [1:0] m, input int d);
        Cmd_Valid = v;
        Cmd_Mode  = m;
        Dead_Cyc  = DEAD_W'(d);
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_target = 0;
        m_gap = 0;
        m_cnt = 0;
    endtask

    // One clock: model consumes the pre-edge inputs, outputs sampled 1ns after edge.
    task automatic tick();
        bit acc;
        int m;
        int d;
        acc = Cmd_Valid && (m_gap == 0);
        m = (Cmd_Mode == 2'b11) ? 0 : int'(Cmd_Mode);
        d = (Dead_Cyc == 0) ? 1 : int'(Dead_Cyc);
        @(posedge Clock);
        if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) begin
                m_mode = m_target;
                if (m_cnt < 15) m_cnt++;
            end
        end else if (acc && m != m_mode) begin
            if (m_mode != 0 && m != 0) begin
                m_mode = 0;
                m_target = m;
                m_gap = d;
            end else begin
                m_mode = m;
                if (m_cnt < 15) m_cnt++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        #12;
        checks++;
        if ({Sel_H, Sel_L} !== 2'b00 || Mode_Cur !== 2'b00) begin
            errors++;
            $display("FAIL reset_sel got %b/%b want 00", {Sel_H, Sel_L}, Mode_Cur);
        end
        checks++;
        if (Cmd_Ready !== 1'b1 || Busy !== 1'b0 || Switch_Cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_ctl got rdy=%b busy=%b cnt=%0d want 1 0 0",
                     Cmd_Ready, Busy, Switch_Cnt);
        end
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_direct();
        drive(1'b1, 2'b01, 0);
        tick();
        drive(1'b0, 2'b00, 0);
        checks++;
        if ({Sel_H, Sel_L} !== 2'b01 || Switch_Cnt !== 4'd1 || Cmd_Ready !== 1'b1) begin
            errors++;
            $display("FAIL direct got sel=%b cnt=%0d rdy=%b want 01 1 1",
                     {Sel_H, Sel_L}, Switch_Cnt, Cmd_Ready);
        end
    endtask

    task automatic test_swap();
        drive(1'b1, 2'b10, 5);
        tick();
        // Held valid with other mode/dead values must be ignored while busy.
        drive(1'b1, 2'b00, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({Sel_H, Sel_L} !== 2'b00 || Cmd_Ready !== 1'b0 || Busy !== 1'b1) begin
                errors++;
                $display("FAIL swap_dead[%0d] got sel=%b rdy=%b busy=%b want 00 0 1",
                         i, {Sel_H, Sel_L}, Cmd_Ready, Busy);
            end
            tick();
        end
        drive(1'b0, 2'b00, 0);
        checks++;
        if ({Sel_H, Sel_L} !== 2'b10 || Mode_Cur !== 2'b10 ||
            Cmd_Ready !== 1'b1 || Switch_Cnt !== 4'd2) begin
            errors++;
            $display("FAIL swap_done got sel=%b mode=%b rdy=%b cnt=%0d want 10 10 1 2",
                     {Sel_H, Sel_L}, Mode_Cur, Cmd_Ready, Switch_Cnt);
        end
    endtask

    task automatic test_dead0();
        drive(1'b1, 2'b01, 0);
        tick();
        drive(1'b0, 2'b00, 0);
        checks++;
        if ({Sel_H, Sel_L} !== 2'b00 || Cmd_Ready !== 1'b0) begin
            errors++;
            $display("FAIL dead0_gap got sel=%b rdy=%b want 00 0", {Sel_H, Sel_L}, Cmd_Ready);
        end
        tick();
        checks++;
        if ({Sel_H, Sel_L} !== 2'b01 || Cmd_Ready !== 1'b1 || Switch_Cnt !== 4'd3) begin
            errors++;
            $display("FAIL dead0_done got sel=%b rdy=%b cnt=%0d want 01 1 3",
                     {Sel_H, Sel_L}, Cmd_Ready, Switch_Cnt);
        end
    endtask

    task automatic test_mode11();
        drive(1'b1, 2'b11, 7);
        tick();
        checks++;
        if ({Sel_H, Sel_L} !== 2'b00 || Cmd_Ready !== 1'b1 || Switch_Cnt !== 4'd4) begin
            errors++;
            $display("FAIL mode11 got sel=%b rdy=%b cnt=%0d want 00 1 4",
                     {Sel_H, Sel_L}, Cmd_Ready, Switch_Cnt);
        end
        drive(1'b1, 2'b01, 0);
        tick();
        drive(1'b0, 2'b00, 0);
        checks++;
        if ({Sel_H, Sel_L} !== 2'b01 || Switch_Cnt !== 4'd5) begin
            errors++;
            $display("FAIL mode11_next got sel=%b cnt=%0d want 01 5", {Sel_H, Sel_L}, Switch_Cnt);
        end
    endtask

    task automatic test_noop();
        drive(1'b1, 2'b01, 3);
        tick();
        tick();
        drive(1'b0, 2'b00, 0);
        checks++;
        if ({Sel_H, Sel_L} !== 2'b01 || Cmd_Ready !== 1'b1 || Switch_Cnt !== 4'd5) begin
            errors++;
            $display("FAIL noop got sel=%b rdy=%b cnt=%0d want 01 1 5",
                     {Sel_H, Sel_L}, Cmd_Ready, Switch_Cnt);
        end
    endtask

    task automatic test_reset_mid_dead();
        drive(1'b1, 2'b10, 9);
        tick();
        drive(1'b0, 2'b00, 0);
        tick();
        tick();
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({Sel_H, Sel_L} !== 2'b00 || Mode_Cur !== 2'b00 || Switch_Cnt !== 4'd0 ||
            Cmd_Ready !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got sel=%b mode=%b cnt=%0d rdy=%b busy=%b want 00 00 0 1 0",
                     {Sel_H, Sel_L}, Mode_Cur, Switch_Cnt, Cmd_Ready, Busy);
        end
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        model_reset();
        drive(1'b1, 2'b10, 0);
        tick();
        drive(1'b0, 2'b00, 0);
        checks++;
        if ({Sel_H, Sel_L} !== 2'b10 || Switch_Cnt !== 4'd1 || Cmd_Ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_next got sel=%b cnt=%0d rdy=%b want 10 1 1",
                     {Sel_H, Sel_L}, Switch_Cnt, Cmd_Ready);
        end
    endtask

    task automatic test_saturation();
        int want;
        want = 1;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, (k % 2 == 0) ? 2'b00 : 2'b01, 0);
            tick();
            if (want < 15) want++;
            checks++;
            if (Switch_Cnt !== CNT_W'(want)) begin
                errors++;
                $display("FAIL sat[%0d] got cnt=%0d want %0d", k, Switch_Cnt, want);
            end
        end
        drive(1'b0, 2'b00, 0);
    endtask

    task automatic test_random();
        bit hold;
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (!hold || Cmd_Ready) begin
                Cmd_Valid = ($urandom_range(0, 3) != 0);
                Cmd_Mode  = 2'($urandom_range(0, 3));
                hold      = ($urandom_range(0, 1) == 1);
            end
            Dead_Cyc = DEAD_W'($urandom_range(0, 6));
            tick();
            checks++;
            if ({Sel_H, Sel_L} !== 2'(m_mode) || Mode_Cur !== 2'(m_mode) ||
                Cmd_Ready !== (m_gap == 0) || Busy !== (m_gap != 0) ||
                Switch_Cnt !== CNT_W'(m_cnt)) begin
                errors++;
                $display("FAIL rand[%0d] got sel=%b mode=%b rdy=%b busy=%b cnt=%0d want %0d %0d %0d %0d %0d",
                         i, {Sel_H, Sel_L}, Mode_Cur, Cmd_Ready, Busy, Switch_Cnt,
                         m_mode, m_mode, (m_gap == 0), (m_gap != 0), m_cnt);
            end
        end
        drive(1'b0, 2'b00, 0);
    endtask

    initial begin
        test_reset();
        test_direct();
        test_swap();
        test_dead0();
        test_mode11();
        test_noop();
        test_reset_mid_dead();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/opn_sel_sequencer.md
# opn_sel_sequencer

Sequencer that drives the Sel_H/Sel_L controls of the output polarity selector in the function-generator output path. It accepts mode commands (off / normal / inverted) over a valid/ready handshake and applies them glitch-free. A programmable all-off dead time is inserted whenever polarity flips directly between normal and inverted. It also reports the applied mode and a transition count to the control logic.

## Interface
- DEAD_W, 8, width of the dead-time count input and of the internal down-counter
- CNT_W, 16, width of the saturating transition counter
- Clock  in  1  system clock; all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Cmd_Valid  in  1  command request
- Cmd_Mode  in  2  requested mode: 00 off, 01 normal, 10 invert, 11 treated as 00
- Cmd_Ready  out  1  command accepted on a cycle where Cmd_Valid and Cmd_Ready are both 1
- Dead_Cyc  in  DEAD_W  dead-time length in cycles; sampled only at accept; 0 is treated as 1
- Sync_Pulse  in  1  waveform period boundary strobe; used only with OPN_SEQ_SYNC_EN
- Sel_H  out  1  registered polarity select, high bit
- Sel_L  out  1  registered polarity select, low bit
- Mode_Cur  out  2  mode currently driven on {Sel_H, Sel_L}; never 11
- Busy  out  1  equals ~Cmd_Ready
- Switch_Cnt  out  CNT_W  number of completed mode changes; saturates at all-ones

## Operation
- States: IDLE, SYNC_WAIT (only with the macro), DEAD.
- IDLE: Cmd_Ready = 1. {Sel_H, Sel_L} = Mode_Cur.
- On accept, the effective new mode M is Cmd_Mode, with 11 mapped to 00.
- No-op: M == Mode_Cur. State stays IDLE. No output change and no count.
- Direct change: one side is off (00 to 01/10, or 01/10 to 00).
  - Mode_Cur and Sel take M at the next edge.
  - State stays IDLE, so commands can be accepted back-to-back every cycle.
- Swap: 01 to 10, or 10 to 01.
  - Load the down-counter with max(Dead_Cyc, 1).
  - Drive Sel = 00 and Mode_Cur = 00 at the next edge, then enter DEAD.
  - In DEAD, decrement the counter each cycle. On the cycle the counter equals 1, load M into Sel and Mode_Cur and return to IDLE.
- Switch_Cnt increments by 1 for every direct change or completed swap, on the edge where M is applied. A swap counts once, not twice. The counter holds at 2^CNT_W-1.
- Cmd_Valid while busy is ignored. The command is not latched, and the requester must hold Valid.
- Reset asserted at any time, including mid-DEAD:
  - Sel_H = 0, Sel_L = 0, Mode_Cur = 00, Switch_Cnt = 0, counter = 0, state IDLE.
  - Cmd_Ready = 1 and Busy = 0 immediately.

## Timing
- Accept at edge T.
- Direct change: new Sel is visible after T+1. Ready stays 1 throughout.
- Swap with dead time D (D = max(Dead_Cyc, 1)):
  - Sel = 00 from T+1 through T+D.
  - New Sel is visible at T+D+1.
  - Cmd_Ready = 0 from T+1 until T+D+1, when it returns to 1 together with the new Sel.
- Outputs are registered. There is no combinational path from Cmd_* or Sync_Pulse to Sel.
- Dead_Cyc changes after accept have no effect on the transition in progress.

## Configuration
- OPN_SEQ_SYNC_EN defined:
  - Every non-no-op accept enters SYNC_WAIT. Cmd_Ready = 0 and the old Sel is held.
  - Sync_Pulse is sampled starting the cycle after accept. A pulse coincident with the accept is ignored.
  - On the first cycle with Sync_Pulse = 1, proceed exactly as if accepted on that cycle: a direct change applies at the next edge; a swap enters DEAD with 00 at the next edge.
  - With the macro, direct changes also deassert Ready until they are applied.
- OPN_SEQ_SYNC_EN undefined: no SYNC_WAIT state. Sync_Pulse is ignored and the timing is exactly as above.

## Test plan
- Reset, then accept Mode 01 -> Sel = 01 one cycle later, Switch_Cnt = 1, Ready stays 1.
- From 01, accept Mode 10 with Dead_Cyc = 5 -> Sel = 00 for exactly 5 cycles, then 10. Ready is low for 5 cycles. Switch_Cnt increments by 1.
- Dead_Cyc = 0 swap -> exactly 1 cycle of 00. Mode 11 request -> behaves as off. Repeating the current mode -> no change and no count.
- Reset_n pulsed low mid-DEAD -> Sel = 00, Mode_Cur = 00, Switch_Cnt = 0, Ready = 1 asynchronously. Next command is applied normally.
- Force Switch_Cnt to all-ones (CNT_W = 4 build, 16 alternating off/on commands) -> counter holds at 15.
- With OPN_SEQ_SYNC_EN: accept a swap, then pulse Sync_Pulse 7 cycles later -> old Sel is held 7 cycles, then 00 for D cycles, then the new mode. A Sync_Pulse on the accept cycle alone does not advance.
